// File: rtl/uart_tx_if.sv
// Word-accept handshake and serial-line status bundle for the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] TX_Data_in;
  logic                 TX_Valid;
  logic                 TX_Ready;
  logic                 TX_Serial_out;
  logic                 TX_Busy;
  logic                 TX_Done;

  modport master (
    output TX_Data_in, TX_Valid,
    input  TX_Ready, TX_Serial_out, TX_Busy, TX_Done
  );

  modport slave (
    input  TX_Data_in, TX_Valid,
    output TX_Ready, TX_Serial_out, TX_Busy, TX_Done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WORD_SIZE data bits LSB first, STOP_BITS stop bits,
// idle-high line, bit period of CLKS_PER_BIT clocks shared with the receive path.
module uart_tx #(
  parameter int unsigned WORD_SIZE        = 8,
  parameter int unsigned CLKS_PER_BIT     = 937,
  parameter int unsigned BAUD_COUNT_WIDTH = 10,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic     clk,
  input  logic     reset_b,
  uart_tx_if.slave tx
);

  localparam int unsigned BIT_CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BAUD_COUNT_WIDTH-1:0] BAUD_LAST = BAUD_COUNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0]        DATA_LAST = BIT_CNT_W'(WORD_SIZE - 1);
  localparam logic [BIT_CNT_W-1:0]        STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                      state_q, state_d;
  logic [BAUD_COUNT_WIDTH-1:0] baud_q, baud_d;
  logic [BIT_CNT_W-1:0]        bit_q, bit_d;
  logic [WORD_SIZE-1:0]        shift_q, shift_d;
  logic                        serial_q, serial_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // State, datapath and output registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state plus baud/bit counters and shift register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (tx.TX_Valid && ready_q) begin
          shift_d = tx.TX_Data_in;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_COUNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_COUNT_WIDTH'(1);
        end
      end
      STOP: begin
        // bit counter is reused to count stop bits
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_COUNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so each one comes straight off a flop.
  always_comb begin
    serial_d = 1'b1;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      STOP:    done_d   = (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
      default: serial_d = 1'b1;
    endcase
  end

  assign tx.TX_Serial_out = serial_q;
  assign tx.TX_Ready      = ready_q;
  assign tx.TX_Busy       = busy_q;
  assign tx.TX_Done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a fast instance (4 clk/bit) under random traffic and a
// slow instance (937 clk/bit, 2 stop bits) checked for exact frame geometry.
module tb_uart_tx;
  localparam int unsigned W     = 8;
  localparam int unsigned CPB_A = 4;
  localparam int unsigned SB_A  = 1;
  localparam int unsigned LEN_A = (1 + W + SB_A) * CPB_A;
  localparam int unsigned CPB_B = 937;
  localparam int unsigned SB_B  = 2;
  localparam int unsigned LEN_B = (1 + W + SB_B) * CPB_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit b_done      = 1'b0;

  uart_tx_if #(.WORD_SIZE(W)) a_if ();
  uart_tx_if #(.WORD_SIZE(W)) b_if ();

  uart_tx #(.WORD_SIZE(W), .CLKS_PER_BIT(CPB_A), .BAUD_COUNT_WIDTH(10), .STOP_BITS(SB_A))
    dut_a (.clk(clk), .reset_b(rst_a), .tx(a_if));
  uart_tx #(.WORD_SIZE(W), .CLKS_PER_BIT(CPB_B), .BAUD_COUNT_WIDTH(10), .STOP_BITS(SB_B))
    dut_b (.clk(clk), .reset_b(rst_b), .tx(b_if));

  typedef struct {
    logic [W-1:0] data;
    bit           chk_start;
    int unsigned  start_cyc;
    bit           chk_gap;
  } exp_t;
  exp_t sb_q[$];

  function automatic void check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Expected line level at cycle p of a frame: start, data LSB first, then stop bits.
  function automatic logic model_bit(input logic [W-1:0] d, input int unsigned p,
                                     input int unsigned cpb);
    int unsigned bi = p / cpb;
    if (bi == 0) return 1'b0;
    if (bi <= W) return d[bi-1];
    return 1'b1;
  endfunction

  // Monitor / receiver model for instance A.
  bit           in_frame = 1'b0;
  int unsigned  pos, err_wave, err_hs, last_end_cyc;
  exp_t         cur;
  logic [W-1:0] rx_word;

  always @(negedge clk) begin
    if (!rst_a) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (a_if.TX_Serial_out === 1'b1) begin
          check("idle_ready_busy_done", {a_if.TX_Ready, a_if.TX_Busy, a_if.TX_Done}, 3'b100);
        end else begin
          if (sb_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            cur.data = '0; cur.chk_start = 1'b0; cur.chk_gap = 1'b0; cur.start_cyc = 0;
          end else begin
            cur = sb_q.pop_front();
          end
          if (cur.chk_start) check("start_cycle", cyc, cur.start_cyc);
          if (cur.chk_gap)   check("b2b_gap", cyc - last_end_cyc, 2);
          in_frame = 1'b1; pos = 0; err_wave = 0; err_hs = 0; rx_word = '0;
        end
      end
      if (in_frame) begin
        if (a_if.TX_Serial_out !== model_bit(cur.data, pos, CPB_A)) err_wave++;
        if ({a_if.TX_Ready, a_if.TX_Busy, a_if.TX_Done} !== {1'b0, 1'b1, pos == LEN_A - 1})
          err_hs++;
        if ((pos % CPB_A) == CPB_A / 2 && pos / CPB_A >= 1 && pos / CPB_A <= W)
          rx_word[pos/CPB_A-1] = a_if.TX_Serial_out;
        if (pos == LEN_A - 1) begin
          check("rx_word", rx_word, cur.data);
          check("wave_bad_cycles", err_wave, 0);
          check("handshake_bad_cycles", err_hs, 0);
          last_end_cyc = cyc;
          in_frame = 1'b0;
        end else begin
          pos++;
        end
      end
    end
  end

  // Offer a word at a negedge; returns at the negedge after the accept edge.
  task automatic send_a(input logic [W-1:0] d, input bit hold);
    exp_t e;
    int   n = 0;
    a_if.TX_Data_in = d;
    a_if.TX_Valid   = 1'b1;
    while (a_if.TX_Ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 1, 0);
      a_if.TX_Valid = 1'b0;
      return;
    end
    e.data = d; e.chk_start = 1'b1; e.start_cyc = cyc + 1; e.chk_gap = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) a_if.TX_Valid = 1'b0;
  endtask

  initial begin : main_a
    exp_t e;
    int   n;
    a_if.TX_Valid = 1'b0; a_if.TX_Data_in = '0; rst_a = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {a_if.TX_Serial_out, a_if.TX_Ready, a_if.TX_Busy, a_if.TX_Done}, 4'b1100);
    #2 rst_a = 1'b1;
    repeat (2000) @(negedge clk);

    send_a(8'hA5, 1'b0);
    repeat (45) @(negedge clk);

    // back-to-back with valid held
    send_a(8'h00, 1'b1);
    a_if.TX_Data_in = 8'hFF;
    e.data = 8'hFF; e.chk_start = 1'b0; e.start_cyc = 0; e.chk_gap = 1'b1;
    sb_q.push_back(e);
    n = 0;
    while (a_if.TX_Ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_seen", n < 200, 1);
    @(negedge clk);
    a_if.TX_Valid = 1'b0;
    repeat (45) @(negedge clk);

    // input churn during a frame must not disturb it
    send_a(8'h3C, 1'b0);
    for (int i = 0; i < 38; i++) begin
      a_if.TX_Data_in = W'($urandom);
      a_if.TX_Valid   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    a_if.TX_Valid = 1'b0;
    repeat (6) @(negedge clk);

    // reset during data bit 3
    send_a(8'hC3, 1'b0);
    repeat (17) @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("reset_mid_frame", {a_if.TX_Serial_out, a_if.TX_Ready, a_if.TX_Busy, a_if.TX_Done}, 4'b1100);
    @(negedge clk);
    @(negedge clk);
    #2 rst_a = 1'b1;
    @(negedge clk);
    send_a(8'h5A, 1'b0);
    repeat (45) @(negedge clk);

    // random words with random gaps
    for (int k = 0; k < 12; k++) begin
      send_a(W'($urandom), 1'b0);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end

    n = 0;
    while ((sb_q.size() != 0 || in_frame) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_frames", sb_q.size() + int'(in_frame), 0);

    n = 0;
    while (!b_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("b_finished", b_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Instance B: single 8'h81 frame with two stop bits at the full bit period.
  initial begin : run_b
    int unsigned bad_edge, bad_wave, done_pos, n_done;
    logic        prev, line;
    b_if.TX_Valid = 1'b0; b_if.TX_Data_in = '0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
    b_if.TX_Data_in = 8'h81;
    b_if.TX_Valid   = 1'b1;
    @(negedge clk);
    b_if.TX_Valid = 1'b0;
    bad_edge = 0; bad_wave = 0; done_pos = 0; n_done = 0; prev = 1'b1;
    for (int p = 0; p < int'(LEN_B) + 5; p++) begin
      if (p > 0) @(negedge clk);
      line = b_if.TX_Serial_out;
      if (line !== prev && (p % CPB_B) != 0) bad_edge++;
      if (p < int'(LEN_B) && line !== model_bit(8'h81, p, CPB_B)) bad_wave++;
      if (p >= int'(LEN_B) && line !== 1'b1) bad_wave++;
      if (b_if.TX_Done === 1'b1) begin
        done_pos = p;
        n_done++;
      end
      prev = line;
    end
    check("b_edges_off_grid", bad_edge, 0);
    check("b_wave_bad_cycles", bad_wave, 0);
    check("b_done_pulses", n_done, 1);
    check("b_frame_len", done_pos + 1, 10307);
    check("b_stop_len", done_pos + 1 - 9 * CPB_B, 1874);
    check("b_ready_after", {b_if.TX_Ready, b_if.TX_Busy}, 2'b10);
    b_done = 1'b1;
  end

endmodule
